// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: one pixel-in channel and one pooled-out channel.
// A beat transfers on any rising edge where valid && ready; the producer holds data/valid stable until then.
interface maxpool2x2_stream_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-ordered, channel-packed pixel stream.
// Needs only a half-row buffer of horizontal-pair results; output is a single register stage.
module maxpool2x2_stream #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 2,
    parameter int IN_W     = 10,
    parameter int IN_H     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    maxpool2x2_stream_if.slave      bus
);
    localparam int DW   = CHANNELS * BITWIDTH;
    localparam int HW   = BITWIDTH + 1;
    localparam int SW   = BITWIDTH + 2;
    localparam int HALF = IN_W / 2;
    localparam int CW   = $clog2(IN_W);
    localparam int RW   = $clog2(IN_H);

    if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_w
        $error("maxpool2x2_stream: IN_W must be even and at least 4");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_h
        $error("maxpool2x2_stream: IN_H must be even");
    end

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic                   mode_q;
    logic [DW-1:0]          hreg;
    logic [CHANNELS*HW-1:0] linebuf [HALF];
    logic [CHANNELS*HW-1:0] lb_rd;
    logic [CHANNELS*HW-1:0] hp_bus;
    logic [DW-1:0]          win_bus;
    logic                   accept;
    logic                   load;
    logic                   frame_start;
    logic                   col_last;
    logic                   row_last;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign frame_start  = (row == '0) && (col == '0);
    assign col_last     = (col == CW'(IN_W - 1));
    assign row_last     = (row == RW'(IN_H - 1));
    assign load         = accept && row[0] && col[0];
    assign lb_rd        = linebuf[col[CW-1:1]];

    // Horizontal pair op, then vertical op against the buffered pair from the row above.
    always_comb begin
        logic signed [BITWIDTH-1:0] a;
        logic signed [BITWIDTH-1:0] b;
        logic signed [HW-1:0]       h;
        logic signed [HW-1:0]       l;
        logic signed [SW-1:0]       s;
        logic signed [BITWIDTH-1:0] w;
        hp_bus  = '0;
        win_bus = '0;
        a = '0; b = '0; h = '0; l = '0; s = '0; w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            a = hreg[c*BITWIDTH +: BITWIDTH];
            b = bus.in_data[c*BITWIDTH +: BITWIDTH];
            if (mode_q) h = HW'(a) + HW'(b);
            else        h = (a > b) ? HW'(a) : HW'(b);
            hp_bus[c*HW +: HW] = h;

            l = lb_rd[c*HW +: HW];
            if (mode_q) begin
                s = SW'(l) + SW'(h);
                s = s >>> 2;
                w = s[BITWIDTH-1:0];
            end else begin
                w = (l > h) ? l[BITWIDTH-1:0] : h[BITWIDTH-1:0];
            end
            win_bus[c*BITWIDTH +: BITWIDTH] = w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
            hreg   <= '0;
        end else if (accept) begin
            if (frame_start) mode_q <= mode;
            if (!col[0])     hreg   <= bus.in_data;
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && !row[0] && col[0]) linebuf[col[CW-1:1]] <= hp_bus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else if (load) begin
            bus.out_data  <= win_bus;
            bus.out_valid <= 1'b1;
            bus.out_last  <= row_last && col_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: golden pooling model feeds an expected queue,
// a negedge monitor pops and compares every output transfer.
module tb_maxpool2x2_stream;
    localparam int BW = 16;
    localparam int CH = 2;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int DW = CH * BW;

    logic clk;
    logic rst_n;
    logic mode;
    logic stall_en;
    int   n_chk;
    int   n_err;
    int   n_out;
    int   n_last;

    logic [DW:0]   exp_q [$];
    logic [DW-1:0] frm [H][W];

    maxpool2x2_stream_if #(.DW(DW)) bus ();

    maxpool2x2_stream #(.BITWIDTH(BW), .CHANNELS(CH), .IN_W(W), .IN_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (bus.out_last) n_last++;
            if (exp_q.size() == 0) begin
                check("extra_out", {31'd0, bus.out_last, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("out", {31'd0, bus.out_last, bus.out_data}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    // golden model: pushes expected outputs whose bottom-right beat index is below limit
    task automatic push_golden(input bit m, input int limit);
        for (int i = 0; i < H / 2; i++) begin
            for (int j = 0; j < W / 2; j++) begin
                logic [DW-1:0] res;
                int br;
                br  = (2 * i + 1) * W + 2 * j + 1;
                res = '0;
                if (br < limit) begin
                    for (int c = 0; c < CH; c++) begin
                        int v [4];
                        int r;
                        v[0] = int'($signed(frm[2*i][2*j][c*BW +: BW]));
                        v[1] = int'($signed(frm[2*i][2*j+1][c*BW +: BW]));
                        v[2] = int'($signed(frm[2*i+1][2*j][c*BW +: BW]));
                        v[3] = int'($signed(frm[2*i+1][2*j+1][c*BW +: BW]));
                        if (m) begin
                            r = (v[0] + v[1] + v[2] + v[3]) >>> 2;
                        end else begin
                            r = v[0];
                            for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
                        end
                        res[c*BW +: BW] = r[BW-1:0];
                    end
                    exp_q.push_back({(br == W * H - 1), res});
                end
            end
        end
    endtask

    task automatic fill(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int v;
                int k;
                int p;
                logic [BW-1:0] e0;
                logic [BW-1:0] e1;
                v = r * 10 + c;
                k = ((r / 2) * (W / 2) + (c / 2)) % 3;
                p = (r % 2) * 2 + (c % 2);
                if (pat == 0) begin
                    e0 = BW'(v);
                    e1 = BW'(-v);
                end else if (pat == 1) begin
                    e0 = BW'($urandom);
                    e1 = BW'($urandom);
                end else begin
                    e0 = (k == 0) ? ((p == 3) ? 16'h8001 : 16'h8000) : (k == 1) ? 16'h7FFF : 16'h8000;
                    e1 = (k == 2) ? ((p == 3) ? 16'h8001 : 16'h8000) : (k == 0) ? 16'h7FFF : 16'h8000;
                end
                frm[r][c] = {e1, e0};
            end
        end
    endtask

    // driver
    task automatic send_pix(input logic [DW-1:0] d, input bit gaps);
        bit acc;
        int guard;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 64'(guard), 64'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit m, input bit gaps, input int toggle_at, input int beats);
        mode = m;
        for (int idx = 0; idx < beats; idx++) begin
            if (idx == toggle_at) mode = ~mode;
            send_pix(frm[idx / W][idx % W], gaps);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int o0;
        int l0;
        n_chk = 0; n_err = 0; n_out = 0; n_last = 0;
        stall_en = 1'b0;
        rst_n = 1'b0;
        mode = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ramp pattern, max then average, unstalled
        for (int m = 0; m < 2; m++) begin
            fill(0);
            o0 = n_out; l0 = n_last;
            push_golden(m[0], W * H);
            send_frame(m[0], 1'b0, -1, W * H);
            drain();
            check("frame_outputs", 64'(n_out - o0), 64'd25);
            check("frame_lasts", 64'(n_last - l0), 64'd1);
        end

        // signed extremes, max then average
        fill(2);
        push_golden(1'b0, W * H);
        send_frame(1'b0, 1'b0, -1, W * H);
        push_golden(1'b1, W * H);
        send_frame(1'b1, 1'b0, -1, W * H);
        drain();

        // three back-to-back random frames with input gaps and output stalls
        stall_en = 1'b1;
        l0 = n_last;
        for (int f = 0; f < 3; f++) begin
            fill(1);
            push_golden(f[0], W * H);
            send_frame(f[0], 1'b1, -1, W * H);
        end
        drain();
        stall_en = 1'b0;
        drain();
        check("stalled_lasts", 64'(n_last - l0), 64'd3);

        // reset after 37 beats, then a full frame
        fill(0);
        push_golden(1'b0, 37);
        send_frame(1'b0, 1'b0, -1, 37);
        drain();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check("midrst_out_last", 64'(bus.out_last), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill(1);
        o0 = n_out;
        push_golden(1'b1, W * H);
        send_frame(1'b1, 1'b0, -1, W * H);
        drain();
        check("post_rst_outputs", 64'(n_out - o0), 64'd25);

        // mode toggled mid-frame takes effect on the next frame only
        fill(0);
        push_golden(1'b0, W * H);
        send_frame(1'b0, 1'b0, 50, W * H);
        push_golden(1'b1, W * H);
        send_frame(1'b1, 1'b0, -1, W * H);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
